// File: rtl/pong_pkg.sv
// Shared pong definitions: FSM states, direction encodings, playfield defaults.
package pong_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SERVE_WAIT = 2'd1,
      PLAY       = 2'd2,
      SCORED     = 2'd3
   } state_t;

   localparam logic DIR_RIGHT = 1'b1;
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_DOWN  = 1'b1;
   localparam logic DIR_UP    = 1'b0;

   localparam int unsigned FIELD_W_DEFAULT = 320;
   localparam int unsigned FIELD_H_DEFAULT = 240;

endpackage

// File: rtl/paddle_overlap.sv
// Combinational test of whether the ball's vertical span overlaps a paddle.
module paddle_overlap #(
   parameter int unsigned COORD_W    = 9,
   parameter int unsigned SIZE       = 4,
   parameter int unsigned PADDLE_LEN = 32
) (
   input  logic [COORD_W-1:0] ball_v,
   input  logic [COORD_W-1:0] paddle,
   output logic               hit_c
);

   // Extra headroom bits so the sums below never wrap.
   localparam int unsigned EW = COORD_W + 2;

   logic [EW-1:0] v_ext;
   logic [EW-1:0] p_ext;

   assign v_ext = EW'(ball_v);
   assign p_ext = EW'(paddle);

   // Ball spans [v, v+SIZE), paddle spans [p, p+PADDLE_LEN).
   assign hit_c = ((v_ext + EW'(SIZE)) > p_ext) && (v_ext < (p_ext + EW'(PADDLE_LEN)));

endmodule

// File: rtl/ball_engine.sv
// Pong ball mover: serve/score FSM, variable speed, wall clamping, paddle hits.
module ball_engine
   import pong_pkg::*;
#(
   parameter int unsigned COORD_W     = 9,
   parameter int unsigned MIN_H       = 0,
   parameter int unsigned MAX_H       = FIELD_W_DEFAULT,
   parameter int unsigned MIN_V       = 0,
   parameter int unsigned MAX_V       = FIELD_H_DEFAULT,
   parameter int unsigned SIZE        = 4,
   parameter int unsigned PADDLE_LEN  = 32,
   parameter int unsigned MAX_SPEED   = 4,
   parameter int unsigned SERVE_DELAY = 60
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               tick,
   input  logic               serve,
   input  logic [COORD_W-1:0] player1_paddle,
   input  logic [COORD_W-1:0] player2_paddle,
   output logic [COORD_W-1:0] ball_h,
   output logic [COORD_W-1:0] ball_v,
   output logic               ball_active,
   output logic               hit,
   output logic               score_p1,
   output logic               score_p2
);

   localparam int unsigned SW    = COORD_W + 1;
   localparam int unsigned SPD_W = $clog2(MAX_SPEED + 1);
   localparam int unsigned CNT_W = $clog2(SERVE_DELAY + 1);

   localparam logic [COORD_W-1:0] START_H = COORD_W'((MIN_H + MAX_H - SIZE) / 2);
   localparam logic [COORD_W-1:0] START_V = COORD_W'((MIN_V + MAX_V - SIZE) / 2);
   localparam logic [COORD_W-1:0] LIM_H_LO = COORD_W'(MIN_H);
   localparam logic [COORD_W-1:0] LIM_H_HI = COORD_W'(MAX_H - SIZE);
   localparam logic [COORD_W-1:0] LIM_V_LO = COORD_W'(MIN_V);
   localparam logic [COORD_W-1:0] LIM_V_HI = COORD_W'(MAX_V - SIZE);

   localparam logic signed [SW-1:0] S_H_LO = SW'(MIN_H);
   localparam logic signed [SW-1:0] S_H_HI = SW'(MAX_H - SIZE);
   localparam logic signed [SW-1:0] S_V_LO = SW'(MIN_V);
   localparam logic signed [SW-1:0] S_V_HI = SW'(MAX_V - SIZE);

   localparam logic [SPD_W-1:0] SPEED_MIN = SPD_W'(1);
   localparam logic [SPD_W-1:0] SPEED_MAX = SPD_W'(MAX_SPEED);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SERVE_DELAY - 1);

   state_t             state, state_n;
   logic               dir_h, dir_h_n;
   logic               dir_v, dir_v_n;
   logic [SPD_W-1:0]   speed, speed_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [COORD_W-1:0] ball_h_n, ball_v_n;
   logic               ball_active_n, hit_n, score_p1_n, score_p2_n;

   logic signed [SW-1:0] h_s, v_s, spd_s, next_h, next_v;
   logic [COORD_W-1:0]   v_new;
   logic                 dir_v_new;
   logic                 ovl_p1_c, ovl_p2_c;

   // Candidate positions in a signed, one-bit-wider space so edges never wrap.
   always_comb begin
      h_s    = SW'(ball_h);
      v_s    = SW'(ball_v);
      spd_s  = SW'(speed);
      next_h = (dir_h == DIR_RIGHT) ? (h_s + spd_s) : (h_s - spd_s);
      next_v = (dir_v == DIR_DOWN)  ? (v_s + spd_s) : (v_s - spd_s);
   end

   // Vertical clamp and bounce; its result also feeds the paddle overlap tests.
   always_comb begin
      v_new     = next_v[COORD_W-1:0];
      dir_v_new = dir_v;
      if (next_v <= S_V_LO) begin
         v_new     = LIM_V_LO;
         dir_v_new = DIR_DOWN;
      end else if (next_v >= S_V_HI) begin
         v_new     = LIM_V_HI;
         dir_v_new = DIR_UP;
      end
   end

   paddle_overlap #(
      .COORD_W    (COORD_W),
      .SIZE       (SIZE),
      .PADDLE_LEN (PADDLE_LEN)
   ) u_ovl_p1 (
      .ball_v (v_new),
      .paddle (player1_paddle),
      .hit_c  (ovl_p1_c)
   );

   paddle_overlap #(
      .COORD_W    (COORD_W),
      .SIZE       (SIZE),
      .PADDLE_LEN (PADDLE_LEN)
   ) u_ovl_p2 (
      .ball_v (v_new),
      .paddle (player2_paddle),
      .hit_c  (ovl_p2_c)
   );

   // Next-state and next-register values for the serve/play/score sequence.
   always_comb begin
      state_n    = state;
      dir_h_n    = dir_h;
      dir_v_n    = dir_v;
      speed_n    = speed;
      cnt_n      = cnt;
      ball_h_n   = ball_h;
      ball_v_n   = ball_v;
      hit_n      = 1'b0;
      score_p1_n = 1'b0;
      score_p2_n = 1'b0;

      unique case (state)
         IDLE: begin
            if (serve) begin
               state_n = SERVE_WAIT;
               cnt_n   = '0;
            end
         end

         SERVE_WAIT: begin
            if (tick) begin
               if (cnt == CNT_LAST) begin
                  state_n = PLAY;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
         end

         PLAY: begin
            if (tick) begin
               ball_v_n = v_new;
               dir_v_n  = dir_v_new;
               if ((dir_h == DIR_LEFT) && (next_h <= S_H_LO)) begin
                  ball_h_n = LIM_H_LO;
                  if (ovl_p1_c) begin
                     dir_h_n = DIR_RIGHT;
                     hit_n   = 1'b1;
                     speed_n = (speed < SPEED_MAX) ? (speed + SPD_W'(1)) : SPEED_MAX;
                  end else begin
                     score_p2_n = 1'b1;
                     state_n    = SCORED;
                  end
               end else if ((dir_h == DIR_RIGHT) && (next_h >= S_H_HI)) begin
                  ball_h_n = LIM_H_HI;
                  if (ovl_p2_c) begin
                     dir_h_n = DIR_LEFT;
                     hit_n   = 1'b1;
                     speed_n = (speed < SPEED_MAX) ? (speed + SPD_W'(1)) : SPEED_MAX;
                  end else begin
                     score_p1_n = 1'b1;
                     state_n    = SCORED;
                  end
               end else begin
                  ball_h_n = next_h[COORD_W-1:0];
               end
            end
         end

         SCORED: begin
            // score_p1/score_p2 still hold the pulse that sent us here.
            ball_h_n = START_H;
            ball_v_n = START_V;
            speed_n  = SPEED_MIN;
            dir_h_n  = score_p1 ? DIR_RIGHT : DIR_LEFT;
            cnt_n    = '0;
            state_n  = SERVE_WAIT;
         end

         default: state_n = IDLE;
      endcase

      ball_active_n = (state_n == PLAY);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         ball_h      <= START_H;
         ball_v      <= START_V;
         dir_h       <= DIR_RIGHT;
         dir_v       <= DIR_DOWN;
         speed       <= SPEED_MIN;
         cnt         <= '0;
         ball_active <= 1'b0;
         hit         <= 1'b0;
         score_p1    <= 1'b0;
         score_p2    <= 1'b0;
      end else begin
         state       <= state_n;
         ball_h      <= ball_h_n;
         ball_v      <= ball_v_n;
         dir_h       <= dir_h_n;
         dir_v       <= dir_v_n;
         speed       <= speed_n;
         cnt         <= cnt_n;
         ball_active <= ball_active_n;
         hit         <= hit_n;
         score_p1    <= score_p1_n;
         score_p2    <= score_p2_n;
      end
   end

endmodule

// File: tb/tb_ball_engine.sv
// Directed self-checking bench for ball_engine.
module tb_ball_engine;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       tick  = 1'b0;
   logic       serve = 1'b0;
   logic [8:0] player1_paddle = 9'd100;
   logic [8:0] player2_paddle = 9'd180;
   logic [8:0] ball_h;
   logic [8:0] ball_v;
   logic       ball_active;
   logic       hit;
   logic       score_p1;
   logic       score_p2;

   int checks   = 0;
   int failures = 0;

   ball_engine dut (
      .clock          (clock),
      .reset          (reset),
      .tick           (tick),
      .serve          (serve),
      .player1_paddle (player1_paddle),
      .player2_paddle (player2_paddle),
      .ball_h         (ball_h),
      .ball_v         (ball_v),
      .ball_active    (ball_active),
      .hit            (hit),
      .score_p1       (score_p1),
      .score_p2       (score_p2)
   );

   always #5 clock = ~clock;

   // One tick cycle followed by one quiet cycle; ends on a negedge after the update.
   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock) tick = 1'b1;
         @(negedge clock) tick = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clock) reset = 1'b1;
      @(negedge clock);
      @(negedge clock) reset = 1'b0;
   endtask

   task automatic do_serve();
      @(negedge clock) serve = 1'b1;
      @(negedge clock) serve = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (ball_h !== 9'd158 || ball_v !== 9'd118) begin
         failures++;
         $display("FAIL reset_pos got=(%0d,%0d) exp=(158,118)", ball_h, ball_v);
      end
      checks++;
      if ({ball_active, hit, score_p1, score_p2} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=0000", {ball_active, hit, score_p1, score_p2});
      end
      do_ticks(100);
      checks++;
      if (ball_h !== 9'd158 || ball_v !== 9'd118 || ball_active !== 1'b0) begin
         failures++;
         $display("FAIL idle_hold got=(%0d,%0d,a=%b) exp=(158,118,a=0)", ball_h, ball_v, ball_active);
      end
   endtask

   task automatic test_serve_delay();
      do_serve();
      do_ticks(59);
      checks++;
      if (ball_active !== 1'b0) begin
         failures++;
         $display("FAIL serve_59 active got=%b exp=0", ball_active);
      end
      do_ticks(1);
      checks++;
      if (ball_active !== 1'b1 || ball_h !== 9'd158 || ball_v !== 9'd118) begin
         failures++;
         $display("FAIL serve_60 got=(a=%b,%0d,%0d) exp=(a=1,158,118)", ball_active, ball_h, ball_v);
      end
      do_ticks(1);
      checks++;
      if (ball_h !== 9'd159 || ball_v !== 9'd119) begin
         failures++;
         $display("FAIL first_move got=(%0d,%0d) exp=(159,119)", ball_h, ball_v);
      end
   endtask

   task automatic test_wall_bounce();
      do_ticks(117);
      checks++;
      if (ball_h !== 9'd276 || ball_v !== 9'd236) begin
         failures++;
         $display("FAIL bottom_clamp got=(%0d,%0d) exp=(276,236)", ball_h, ball_v);
      end
      do_ticks(1);
      checks++;
      if (ball_v !== 9'd235) begin
         failures++;
         $display("FAIL bottom_bounce got=%0d exp=235", ball_v);
      end
   endtask

   task automatic test_paddle_hit();
      do_ticks(38);
      checks++;
      if (ball_h !== 9'd315 || ball_v !== 9'd197 || hit !== 1'b0) begin
         failures++;
         $display("FAIL pre_hit got=(%0d,%0d,h=%b) exp=(315,197,h=0)", ball_h, ball_v, hit);
      end
      do_ticks(1);
      checks++;
      if (ball_h !== 9'd316 || ball_v !== 9'd196 || hit !== 1'b1 || score_p1 !== 1'b0) begin
         failures++;
         $display("FAIL right_hit got=(%0d,%0d,h=%b,s1=%b) exp=(316,196,h=1,s1=0)",
                  ball_h, ball_v, hit, score_p1);
      end
      @(negedge clock);
      checks++;
      if (hit !== 1'b0) begin
         failures++;
         $display("FAIL hit_pulse_width got=%b exp=0", hit);
      end
      do_ticks(1);
      checks++;
      if (ball_h !== 9'd314 || ball_v !== 9'd194) begin
         failures++;
         $display("FAIL speed2 got=(%0d,%0d) exp=(314,194)", ball_h, ball_v);
      end
   endtask

   task automatic test_left_hit();
      // k ticks after the right hit: h=316-2k, v=196-2k until top clamp at k=98.
      do_ticks(97);
      checks++;
      if (ball_v !== 9'd0 || ball_h !== 9'd120) begin
         failures++;
         $display("FAIL top_clamp got=(%0d,%0d) exp=(120,0)", ball_h, ball_v);
      end
      do_ticks(59);
      checks++;
      if (ball_h !== 9'd2 || ball_v !== 9'd118) begin
         failures++;
         $display("FAIL pre_left got=(%0d,%0d) exp=(2,118)", ball_h, ball_v);
      end
      do_ticks(1);
      checks++;
      if (ball_h !== 9'd0 || ball_v !== 9'd120 || hit !== 1'b1 || score_p2 !== 1'b0) begin
         failures++;
         $display("FAIL left_hit got=(%0d,%0d,h=%b,s2=%b) exp=(0,120,h=1,s2=0)",
                  ball_h, ball_v, hit, score_p2);
      end
      do_ticks(1);
      checks++;
      if (ball_h !== 9'd3 || ball_v !== 9'd123) begin
         failures++;
         $display("FAIL speed3 got=(%0d,%0d) exp=(3,123)", ball_h, ball_v);
      end
   endtask

   task automatic test_miss();
      player2_paddle = 9'd0;
      do_reset();
      do_serve();
      do_ticks(60);
      do_ticks(157);
      checks++;
      if (ball_h !== 9'd315 || score_p1 !== 1'b0) begin
         failures++;
         $display("FAIL pre_miss got=(%0d,s1=%b) exp=(315,s1=0)", ball_h, score_p1);
      end
      do_ticks(1);
      checks++;
      if (score_p1 !== 1'b1 || score_p2 !== 1'b0 || hit !== 1'b0 || ball_active !== 1'b0) begin
         failures++;
         $display("FAIL miss_pulse got=(s1=%b,s2=%b,h=%b,a=%b) exp=(1,0,0,0)",
                  score_p1, score_p2, hit, ball_active);
      end
      @(negedge clock);
      checks++;
      if (ball_h !== 9'd158 || ball_v !== 9'd118 || score_p1 !== 1'b0) begin
         failures++;
         $display("FAIL recentre got=(%0d,%0d,s1=%b) exp=(158,118,s1=0)", ball_h, ball_v, score_p1);
      end
      do_ticks(59);
      checks++;
      if (ball_active !== 1'b0 || ball_h !== 9'd158) begin
         failures++;
         $display("FAIL rewait got=(a=%b,%0d) exp=(a=0,158)", ball_active, ball_h);
      end
      do_ticks(1);
      checks++;
      if (ball_active !== 1'b1) begin
         failures++;
         $display("FAIL replay active got=%b exp=1", ball_active);
      end
      do_ticks(1);
      checks++;
      if (ball_h !== 9'd159 || ball_v !== 9'd117) begin
         failures++;
         $display("FAIL reserve_move got=(%0d,%0d) exp=(159,117)", ball_h, ball_v);
      end
   endtask

   task automatic test_reset_mid_play();
      player2_paddle = 9'd180;
      do_reset();
      do_serve();
      do_ticks(60);
      do_ticks(50);
      checks++;
      if (ball_h !== 9'd208 || ball_v !== 9'd168) begin
         failures++;
         $display("FAIL play50 got=(%0d,%0d) exp=(208,168)", ball_h, ball_v);
      end
      // Reset coincides with a tick; the tick must not move the ball.
      @(negedge clock) begin reset = 1'b1; tick = 1'b1; end
      @(negedge clock) begin reset = 1'b0; tick = 1'b0; end
      checks++;
      if (ball_h !== 9'd158 || ball_v !== 9'd118 || ball_active !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset got=(%0d,%0d,a=%b) exp=(158,118,a=0)", ball_h, ball_v, ball_active);
      end
      do_ticks(5);
      checks++;
      if (ball_h !== 9'd158 || ball_active !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset got=(%0d,a=%b) exp=(158,a=0)", ball_h, ball_active);
      end
      // Serve with a simultaneous tick: the tick is not counted toward the delay.
      @(negedge clock) begin serve = 1'b1; tick = 1'b1; end
      @(negedge clock) begin serve = 1'b0; tick = 1'b0; end
      do_ticks(59);
      checks++;
      if (ball_active !== 1'b0) begin
         failures++;
         $display("FAIL serve_tick_ignored active got=%b exp=0", ball_active);
      end
      do_ticks(1);
      do_ticks(1);
      checks++;
      if (ball_active !== 1'b1 || ball_h !== 9'd159 || ball_v !== 9'd119) begin
         failures++;
         $display("FAIL post_reset_move got=(a=%b,%0d,%0d) exp=(a=1,159,119)",
                  ball_active, ball_h, ball_v);
      end
   endtask

   initial begin
      test_reset();
      test_serve_delay();
      test_wall_bounce();
      test_paddle_hit();
      test_left_hit();
      test_miss();
      test_reset_mid_play();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
